// File: rtl/fetch_buffer_pkg.sv
// Shared state encodings and helpers for the per-core fetch buffer.
package fetch_buffer_pkg;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'b000,
        FS_FETCHING = 3'b001,
        FS_FETCHED  = 3'b010
    } fetcher_state_t;

    typedef enum logic [2:0] {
        CS_IDLE    = 3'd0,
        CS_FETCH   = 3'd1,
        CS_DECODE  = 3'd2,
        CS_REQUEST = 3'd3,
        CS_WAIT    = 3'd4,
        CS_EXECUTE = 3'd5,
        CS_UPDATE  = 3'd6,
        CS_DONE    = 3'd7
    } core_state_t;

    localparam int unsigned STAT_BITS = 16;

    // Saturating increment for the statistics counters
    function automatic logic [STAT_BITS-1:0] sat_inc(input logic [STAT_BITS-1:0] v);
        return (v == {STAT_BITS{1'b1}}) ? v : v + STAT_BITS'(1);
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Scheduler fetch handshake plus program-memory read channel for one core.
interface fetch_buffer_if import fetch_buffer_pkg::*; #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 16
) ();

    core_state_t           core_state;
    logic [ADDR_BITS-1:0]  current_pc;
    logic                  flush;
    logic                  mem_read_valid;
    logic [ADDR_BITS-1:0]  mem_read_address;
    logic                  mem_read_ready;
    logic [DATA_BITS-1:0]  mem_read_data;
    fetcher_state_t        fetcher_state;
    logic [DATA_BITS-1:0]  instruction;

    modport slave (
        input  core_state, current_pc, flush, mem_read_ready, mem_read_data,
        output mem_read_valid, mem_read_address, fetcher_state, instruction
    );

    modport master (
        output core_state, current_pc, flush, mem_read_ready, mem_read_data,
        input  mem_read_valid, mem_read_address, fetcher_state, instruction
    );

endinterface

// File: rtl/fetch_buffer_store.sv
// Direct-mapped tag/data/valid storage: one lookup port, one fill port, flush.
module fetch_buffer_store #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned ENTRIES   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [ADDR_BITS-1:0] rd_pc,
    output logic                 rd_hit_c,
    output logic [DATA_BITS-1:0] rd_data_c,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_pc,
    input  logic [DATA_BITS-1:0] wr_data
);

    localparam int unsigned IDX      = $clog2(ENTRIES);
    localparam int unsigned TAG_BITS = ADDR_BITS - IDX;

    logic [TAG_BITS-1:0]  tag_q  [ENTRIES];
    logic [DATA_BITS-1:0] data_q [ENTRIES];
    logic [ENTRIES-1:0]   valid_q;

    logic [IDX-1:0]      rd_idx;
    logic [TAG_BITS-1:0] rd_tag;
    logic [IDX-1:0]      wr_idx;
    logic [TAG_BITS-1:0] wr_tag;

    assign rd_idx = rd_pc[IDX-1:0];
    assign rd_tag = rd_pc[ADDR_BITS-1:IDX];
    assign wr_idx = wr_pc[IDX-1:0];
    assign wr_tag = wr_pc[ADDR_BITS-1:IDX];

    assign rd_hit_c  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data_c = data_q[rd_idx];

    // Flush beats a coincident fill: the entry is written but stays invalid
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Per-core instruction fetch responder with a small direct-mapped buffer.
// Optional hit/miss statistics counters are enabled by FETCH_BUF_STATS_EN.
module fetch_buffer import fetch_buffer_pkg::*; #(
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
    parameter int unsigned BUF_ENTRIES           = 4
) (
    input  logic             clk,
    input  logic             reset,
    fetch_buffer_if.slave    bus
`ifdef FETCH_BUF_STATS_EN
    ,
    output logic [STAT_BITS-1:0] hit_count,
    output logic [STAT_BITS-1:0] miss_count
`endif
);

    localparam int unsigned AW = PROGRAM_MEM_ADDR_BITS;
    localparam int unsigned DW = PROGRAM_MEM_DATA_BITS;

    fetcher_state_t state_q;
    logic           mem_valid_q;
    logic [AW-1:0]  mem_addr_q;
    logic [DW-1:0]  instr_q;

    logic           lookup_hit_c;
    logic [DW-1:0]  lookup_data_c;
    logic           lookup_c;
    logic           fill_c;

    assign lookup_c = (state_q == FS_IDLE) && (bus.core_state == CS_FETCH);
    assign fill_c   = (state_q == FS_FETCHING) && bus.mem_read_ready;

    fetch_buffer_store #(
        .ADDR_BITS (AW),
        .DATA_BITS (DW),
        .ENTRIES   (BUF_ENTRIES)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .rd_pc     (bus.current_pc),
        .rd_hit_c  (lookup_hit_c),
        .rd_data_c (lookup_data_c),
        .wr_en     (fill_c),
        .wr_pc     (mem_addr_q),
        .wr_data   (bus.mem_read_data)
    );

    // Fetch FSM; a request in flight always runs to completion
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FS_IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            instr_q     <= '0;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (lookup_c) begin
                        if (lookup_hit_c) begin
                            instr_q <= lookup_data_c;
                            state_q <= FS_FETCHED;
                        end else begin
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= bus.current_pc;
                            state_q     <= FS_FETCHING;
                        end
                    end
                end
                FS_FETCHING: begin
                    if (bus.mem_read_ready) begin
                        instr_q     <= bus.mem_read_data;
                        mem_valid_q <= 1'b0;
                        state_q     <= FS_FETCHED;
                    end
                end
                FS_FETCHED: begin
                    if (bus.core_state == CS_DECODE) begin
                        state_q <= FS_IDLE;
                    end
                end
                default: begin
                    state_q     <= FS_IDLE;
                    mem_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetcher_state    = state_q;
    assign bus.mem_read_valid   = mem_valid_q;
    assign bus.mem_read_address = mem_addr_q;
    assign bus.instruction      = instr_q;

`ifdef FETCH_BUF_STATS_EN
    // Lookup statistics; survive flush, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (lookup_c) begin
            if (lookup_hit_c) begin
                hit_count <= sat_inc(hit_count);
            end else begin
                miss_count <= sat_inc(miss_count);
            end
        end
    end
`endif

endmodule
